// File: rtl/conv_if.sv
// Sample and result valid/ready handshakes of the FIR engine.
// The engine side uses the slave modport. The producer/consumer side uses the master modport.
interface conv_if #(parameter int DATA_W = 16);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic signed [DATA_W-1:0] result_out;
    logic                     result_sat;
    logic                     result_valid;
    logic                     result_ready;

    modport master (
        output sample_in, sample_valid, result_ready,
        input  sample_ready, result_out, result_sat, result_valid
    );

    modport slave (
        input  sample_in, sample_valid, result_ready,
        output sample_ready, result_out, result_sat, result_valid
    );
endinterface

// File: rtl/conv_engine.sv
// 3-tap FIR engine. One shared multiplier performs one multiply-accumulate per state (MAC0..MAC2).
// The engine then scales and saturates the sum, and holds the result in OUT until it is taken.
module conv_engine #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 12,
    parameter int SHIFT   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*COEFF_W-1:0]   coeff_in,
    input  logic                   clear,
    conv_if.slave                  bus,
    output logic                   busy
);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + 2;
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] x0, x1, x2;
    logic [3*COEFF_W-1:0]     coeff;
    logic signed [ACC_W-1:0]  acc, acc_sum, scaled;
    logic signed [COEFF_W-1:0] c_sel;
    logic signed [DATA_W-1:0] x_sel, sat_val;
    logic signed [PROD_W-1:0] prod;
    logic                     sat_flag;

    // The tap operand pair is selected by state, so only one multiplier is needed.
    always_comb begin
        c_sel = coeff[0 +: COEFF_W];
        x_sel = x0;
        case (state)
            MAC1: begin c_sel = coeff[COEFF_W +: COEFF_W];   x_sel = x1; end
            MAC2: begin c_sel = coeff[2*COEFF_W +: COEFF_W]; x_sel = x2; end
            default: ;
        endcase
        prod    = c_sel * x_sel;
        acc_sum = acc + {{2{prod[PROD_W-1]}}, prod};
        scaled  = acc_sum >>> SHIFT;
        sat_flag = 1'b0;
        sat_val  = scaled[DATA_W-1:0];
        if (scaled > MAX_V) begin
            sat_val  = {1'b0, {(DATA_W-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (scaled < MIN_V) begin
            sat_val  = {1'b1, {(DATA_W-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    assign bus.sample_ready = (state == IDLE) && !clear;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            x0               <= '0;
            x1               <= '0;
            x2               <= '0;
            coeff            <= '0;
            acc              <= '0;
            bus.result_out   <= '0;
            bus.result_sat   <= 1'b0;
            bus.result_valid <= 1'b0;
        end else if (clear) begin
            // Flush: any in-flight or pending result is dropped.
            state            <= IDLE;
            x0               <= '0;
            x1               <= '0;
            x2               <= '0;
            acc              <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.sample_valid) begin
                    x2    <= x1;
                    x1    <= x0;
                    x0    <= bus.sample_in;
                    coeff <= coeff_in;
                    acc   <= '0;
                    state <= MAC0;
                end
                MAC0: begin acc <= acc_sum; state <= MAC1; end
                MAC1: begin acc <= acc_sum; state <= MAC2; end
                MAC2: begin
                    acc              <= acc_sum;
                    bus.result_out   <= sat_val;
                    bus.result_sat   <= sat_flag;
                    bus.result_valid <= 1'b1;
                    state            <= OUT;
                end
                OUT: if (bus.result_ready) begin
                    bus.result_valid <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
